// File: rtl/pdp_types_pkg.sv
// pdp_types_pkg: PDP8 decode bundles shared by the IFD and its execute stand-in.
// Supplies the `ADDR_WIDTH default (12) when the build does not define it.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif

package pdp_types_pkg;

    // Decoded memory-reference instruction flags
    typedef struct packed {
        logic op_and;
        logic op_tad;
        logic op_isz;
        logic op_dca;
        logic op_jms;
        logic op_jmp;
        logic op_iot;
        logic op_nop;
    } pdp_mem_opcode_s;

    // Decoded group op7 (operate) flags
    typedef struct packed {
        logic op_nop;
        logic op_iac;
        logic op_ral;
        logic op_rtl;
        logic op_rar;
        logic op_rtr;
        logic op_cml;
        logic op_cma;
        logic op_cia;
        logic op_cll;
        logic op_cla;
        logic op_hlt;
        logic op_osr;
        logic op_skp;
        logic op_snl;
        logic op_szl;
        logic op_sza;
        logic op_sna;
        logic op_sma;
        logic op_spa;
    } pdp_op7_opcode_s;

    typedef enum logic [1:0] {
        PC_RANDOM = 2'd0,
        PC_SEQ    = 2'd1,
        PC_FIXED  = 2'd2
    } exec_pc_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        STALL = 2'd2,
        HALT  = 2'd3
    } exec_state_e;

    // Galois feedback mask for taps 16,14,13,11 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr16_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/exec_stall_gen_lfsr.sv
// exec_lfsr16: 16-bit Galois LFSR with a parametrised, nonzero seed.
// Reloads the seed on synchronous reset and steps whenever enabled.
import pdp_types_pkg::*;

module exec_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        en_i,
    output logic [15:0] state_o
);

    logic [15:0] state_q;

    // Seed on reset, otherwise advance one step per enabled cycle
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= SEED;
        end else if (en_i) begin
            state_q <= lfsr16_step(state_q);
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/exec_stall_gen.sv
// exec_stall_gen: execute-stage stand-in answering each IFD opcode with a
// random-length stall and a new PC. Option: EXEC_STALL_GEN_HLT_EN (HLT halts).
import pdp_types_pkg::*;

module exec_stall_gen #(
    parameter int          ADDR_WIDTH  = `ADDR_WIDTH,
    parameter int          MIN_STALL   = 1,
    parameter int          MAX_STALL   = 20,
    parameter int          MAX_TRANS   = 30000,
    parameter int          TRANS_WIDTH = 16,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             mode,
    input  logic [ADDR_WIDTH-1:0]  cfg_pc,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  pdp_mem_opcode_s        pdp_mem_opcode,
    input  pdp_op7_opcode_s        pdp_op7_opcode,
    output logic                   stall,
    output logic [ADDR_WIDTH-1:0]  PC_value,
    output logic [TRANS_WIDTH-1:0] trans_count,
    output logic                   done
);

    localparam int unsigned RANGE = MAX_STALL - MIN_STALL + 1;

    exec_state_e            state_q;
    logic                   stall_q;
    logic                   done_q;
    logic [ADDR_WIDTH-1:0]  pc_q;
    logic [TRANS_WIDTH-1:0] trans_count_q;
    logic [7:0]             cnt_q;

    logic [15:0]            lfsr;
    logic                   opcode_active;
    logic                   limit_hit;
    logic [ADDR_WIDTH-1:0]  seq_pc_d;
    logic [ADDR_WIDTH-1:0]  next_pc_d;
    logic [7:0]             stall_len_d;
    logic [TRANS_WIDTH-1:0] trans_count_d;

    exec_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk_i   (clk),
        .reset_i (reset),
        .en_i    (1'b1),
        .state_o (lfsr)
    );

    assign opcode_active = (|pdp_mem_opcode) | (|pdp_op7_opcode);

    // Choose the PC and stall length that an ARM cycle would commit
    always_comb begin
        seq_pc_d    = base_addr + ADDR_WIDTH'(1);
        limit_hit   = 32'(trans_count_q) >= 32'(MAX_TRANS);
        next_pc_d   = ADDR_WIDTH'(lfsr);
        stall_len_d = 8'(MIN_STALL) + 8'(32'(lfsr[7:0]) % RANGE);
        case (mode)
            PC_SEQ:   next_pc_d = seq_pc_d;
            PC_FIXED: next_pc_d = cfg_pc;
            default:  next_pc_d = ADDR_WIDTH'(lfsr);
        endcase
        if (mode != PC_FIXED && next_pc_d == base_addr) begin
            next_pc_d = seq_pc_d;
        end
        if (limit_hit) begin
            next_pc_d = base_addr;
        end
    end

    // Saturating transaction count seen at the end of a stall
    always_comb begin
        trans_count_d = trans_count_q;
        if (!(&trans_count_q)) begin
            trans_count_d = trans_count_q + TRANS_WIDTH'(1);
        end
    end

    // Control FSM with registered stall/PC/count/done outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            stall_q       <= 1'b0;
            pc_q          <= '0;
            trans_count_q <= '0;
            done_q        <= 1'b0;
            cnt_q         <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    stall_q <= 1'b0;
`ifdef EXEC_STALL_GEN_HLT_EN
                    if (pdp_op7_opcode.op_hlt) begin
                        state_q <= HALT;
                        stall_q <= 1'b1;
                        pc_q    <= base_addr;
                        done_q  <= 1'b1;
                    end else
`endif
                    if (opcode_active) begin
                        state_q <= ARM;
                    end
                end
                ARM: begin
                    stall_q <= 1'b1;
                    pc_q    <= next_pc_d;
                    cnt_q   <= stall_len_d;
                    state_q <= STALL;
                end
                STALL: begin
                    if (cnt_q == 8'd1) begin
                        stall_q       <= 1'b0;
                        cnt_q         <= '0;
                        trans_count_q <= trans_count_d;
                        state_q       <= IDLE;
                        if (32'(trans_count_d) == 32'(MAX_TRANS)) begin
                            done_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
`ifdef EXEC_STALL_GEN_HLT_EN
                HALT: begin
                    stall_q <= 1'b1;
                    pc_q    <= base_addr;
                end
`endif
                default: begin
                    state_q <= IDLE;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

    assign stall       = stall_q;
    assign PC_value    = pc_q;
    assign trans_count = trans_count_q;
    assign done        = done_q;

endmodule
